vram_arbiter: RTL and testbench

- Shares the single-port synchronous VRAM (2K x 8, one-cycle read latency) between the display character fetcher and a CPU-side bus master.
- The display fetch path has absolute priority and sees an unchanged timing contract: address in cycle N, data on vram_data in cycle N+1.
- CPU writes are posted into a small write FIFO; CPU reads are single-outstanding and are ordered behind all earlier posted writes.
- Sits between the pixel/char data path, the CPU bus bridge and the VRAM instance.

---
 rtl/vram_arbiter.sv | 126 ++++++++++++
 tb/tb_vram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: display reads take absolute priority, CPU writes are posted
// through a small FIFO, and single-outstanding CPU reads follow all earlier writes.
module vram_arbiter #(
   parameter int AW     = 11,
   parameter int DW     = 8,
   parameter int WDEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic [DW-1:0] disp_data,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   output logic [AW-1:0] sram_addr,
   output logic          sram_we,
   output logic [DW-1:0] sram_wdata,
   input  logic [DW-1:0] sram_rdata,
   output logic          wfifo_full
);

   localparam int IW = $clog2(WDEPTH);
   localparam int PW = IW + 1;

   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_ISSUED} rd_state_e;

   rd_state_e     rd_state_q, rd_state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic          cpu_rvalid_q, cpu_rvalid_d;

   logic [AW-1:0] wfifo_addr_mem [WDEPTH];
   logic [DW-1:0] wfifo_data_mem [WDEPTH];

   logic wfifo_empty;
   logic wr_accept;
   logic rd_accept;
   logic wfifo_pop;
   logic rd_issue;

   // Wrap bit distinguishes full from empty when the index bits match.
   always_comb begin
      wfifo_empty = (wr_ptr_q == rd_ptr_q);
      wfifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
      wr_accept   = cpu_req & cpu_we & ~wfifo_full;
      rd_accept   = cpu_req & ~cpu_we & (rd_state_q == RD_IDLE);
      wfifo_pop   = ~disp_req & ~wfifo_empty;
      rd_issue    = ~disp_req & wfifo_empty & (rd_state_q == RD_WAIT);
      cpu_ack     = wr_accept | rd_accept;
   end

   always_comb begin
      wr_ptr_d    = wr_accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = wfifo_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      rd_addr_d   = rd_accept ? cpu_addr : rd_addr_q;
      cpu_rdata_d = (rd_state_q == RD_ISSUED) ? sram_rdata : cpu_rdata_q;
      cpu_rvalid_d = (rd_state_q == RD_ISSUED);
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         RD_IDLE:   if (rd_accept) rd_state_d = RD_WAIT;
         RD_WAIT:   if (rd_issue)  rd_state_d = RD_ISSUED;
         RD_ISSUED: rd_state_d = RD_IDLE;
         default:   rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      sram_addr  = disp_addr;
      sram_we    = 1'b0;
      sram_wdata = '0;
      if (wfifo_pop) begin
         sram_addr  = wfifo_addr_mem[rd_ptr_q[IW-1:0]];
         sram_wdata = wfifo_data_mem[rd_ptr_q[IW-1:0]];
         sram_we    = 1'b1;
      end else if (rd_issue) begin
         sram_addr = rd_addr_q;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q   <= RD_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rd_addr_q    <= '0;
         cpu_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
      end else begin
         rd_state_q   <= rd_state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_addr_q    <= rd_addr_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_rvalid_q <= cpu_rvalid_d;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers alone decide which entries
   // are valid, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         wfifo_addr_mem[wr_ptr_q[IW-1:0]] <= cpu_addr;
         wfifo_data_mem[wr_ptr_q[IW-1:0]] <= cpu_wdata;
      end
   end

   assign disp_data  = sram_rdata;
   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural VRAM and a scoreboard of
// expected VRAM writes, CPU read returns and display read data.
module tb_vram_arbiter;

   localparam int AW = 11;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;
   logic [AW-1:0] sram_addr;
   logic          sram_we;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata;
   logic          wfifo_full;

   vram_arbiter #(.AW(AW), .DW(DW), .WDEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata), .wfifo_full(wfifo_full)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int a);
      if (a == 'h010) return 8'hAA;
      if (a == 'h011) return 8'h55;
      return DW'(a * 7 + 3);
   endfunction

   // Behavioural single-port synchronous VRAM.
   logic [DW-1:0] vram [2**AW];
   initial for (int i = 0; i < 2**AW; i++) vram[i] = init_val(i);
   always @(posedge clk) begin
      if (sram_we) vram[sram_addr] <= sram_wdata;
      sram_rdata <= vram[sram_addr];
   end

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           exp_wr[$];
   logic [DW-1:0] exp_rd[$];
   logic [DW-1:0] ref_mem [2**AW];
   logic          disp_pend = 1'b0;
   logic [DW-1:0] disp_exp;
   int            n_cmp = 0;
   int            n_err = 0;
   int            n_wr = 0;
   int            n_rv = 0;
   int            cyc = 0;
   int            last_rv_cyc = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sample at the falling edge: scoreboard compare, then record new acks.
   task automatic settle();
      wr_t e;
      logic [DW-1:0] r;
      @(negedge clk);
      if (disp_pend) check("disp_data", disp_data, disp_exp);
      disp_pend = 1'b0;
      if (rst_n && disp_req) begin
         check("disp_slot_addr", sram_addr, disp_addr);
         check("disp_slot_we", sram_we, 0);
         disp_pend = 1'b1;
         disp_exp  = ref_mem[disp_addr];
      end
      if (sram_we) begin
         n_wr++;
         if (exp_wr.size() == 0) check("unexpected_write", sram_we, 0);
         else begin
            e = exp_wr.pop_front();
            check("wr_addr", sram_addr, e.addr);
            check("wr_data", sram_wdata, e.data);
         end
      end
      if (cpu_rvalid) begin
         n_rv++;
         last_rv_cyc = cyc;
         if (exp_rd.size() == 0) check("unexpected_rvalid", cpu_rvalid, 0);
         else begin
            r = exp_rd.pop_front();
            check("cpu_rdata", cpu_rdata, r);
         end
      end
      if (rst_n && cpu_req && cpu_ack) begin
         if (cpu_we) begin
            exp_wr.push_back('{addr: cpu_addr, data: cpu_wdata});
            ref_mem[cpu_addr] = cpu_wdata;
         end else begin
            exp_rd.push_back(ref_mem[cpu_addr]);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic cpu_set(input logic req, input logic we, input int addr, input int data);
      cpu_req   = req;
      cpu_we    = we;
      cpu_addr  = AW'(addr);
      cpu_wdata = DW'(data);
   endtask

   initial begin
      int k;
      int ack_cyc;
      int wr_snap;
      int rv_snap;
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(i);
      rst_n = 1'b0;
      disp_req = 1'b0;
      disp_addr = 11'h02A;
      cpu_set(0, 0, 0, 0);

      // Reset state
      settle();
      check("rst_sram_we", sram_we, 0);
      check("rst_sram_addr", sram_addr, 11'h02A);
      check("rst_full", wfifo_full, 0);
      check("rst_rvalid", cpu_rvalid, 0);
      check("rst_rdata", cpu_rdata, 0);
      adv();
      rst_n = 1'b1;
      adv();

      // Display sweep with idle CPU
      for (int i = 0; i < 64; i++) begin
         disp_req = 1'b1;
         disp_addr = AW'(i);
         settle();
         adv();
      end
      disp_req = 1'b0;
      settle();
      check("sweep_no_writes", n_wr, 0);
      adv();

      // Single posted write then read-back with minimum latency
      cpu_set(1, 1, 'h005, 'h41);
      settle();
      check("t2_wr_ack", cpu_ack, 1);
      adv();
      cpu_set(0, 0, 0, 0);
      settle();
      check("t2_we", sram_we, 1);
      check("t2_addr", sram_addr, 11'h005);
      check("t2_data", sram_wdata, 8'h41);
      adv();
      cpu_set(1, 0, 'h005, 0);
      settle();
      check("t2_rd_ack", cpu_ack, 1);
      ack_cyc = cyc;
      adv();
      cpu_set(0, 0, 0, 0);
      k = 0;
      while (k < 10 && last_rv_cyc < ack_cyc) begin
         settle();
         adv();
         k++;
      end
      check("t2_rvalid_seen", (last_rv_cyc >= ack_cyc), 1);
      check("t2_latency", last_rv_cyc - ack_cyc, 3);

      // FIFO fill while the display holds the port
      k = 0;
      for (int i = 0; i < 10; i++) begin
         disp_req = 1'b1;
         disp_addr = AW'('h040 + i);
         cpu_set(1, 1, 'h200 + k, 'h10 + k);
         settle();
         check("t3_ack", cpu_ack, (i < 4));
         if (cpu_ack) k++;
         if (i == 9) check("t3_full", wfifo_full, 1);
         adv();
      end
      check("t3_acked", k, 4);
      disp_req = 1'b0;
      settle();
      check("t3_still_full_ack", cpu_ack, 0);
      check("t3_drain0", sram_we, 1);
      adv();
      settle();
      check("t3_fifth_ack", cpu_ack, 1);
      check("t3_drain1", sram_we, 1);
      adv();
      cpu_set(0, 0, 0, 0);
      for (int i = 2; i < 5; i++) begin
         settle();
         check("t3_drain_consec", sram_we, 1);
         adv();
      end
      settle();
      check("t3_drained", sram_we, 0);
      check("t3_not_full", wfifo_full, 0);
      adv();

      // Write then read-after-write while the display toggles
      for (int i = 0; i < 8; i++) begin
         disp_req = (i % 2 == 0);
         disp_addr = AW'('h050 + i);
         if (i == 0) cpu_set(1, 1, 'h100, 'h7F);
         else if (i == 1) cpu_set(1, 0, 'h100, 0);
         else cpu_set(0, 0, 0, 0);
         settle();
         if (i <= 1) check("t4_ack", cpu_ack, 1);
         if (i == 1) begin
            check("t4_wr_first_we", sram_we, 1);
            check("t4_wr_first_addr", sram_addr, 11'h100);
         end
         if (i == 3) begin
            check("t4_rd_issue_addr", sram_addr, 11'h100);
            check("t4_rd_issue_we", sram_we, 0);
         end
         if (i == 5) begin
            check("t4_rvalid", cpu_rvalid, 1);
            check("t4_rdata", cpu_rdata, 8'h7F);
         end
         adv();
      end

      // Reset with 3 posted writes and a read waiting
      for (int i = 0; i < 4; i++) begin
         disp_req = 1'b1;
         disp_addr = AW'('h060 + i);
         if (i < 3) cpu_set(1, 1, 'h300 + i, 'hC0 + i);
         else cpu_set(1, 0, 'h300, 0);
         settle();
         check("t5_ack", cpu_ack, 1);
         adv();
      end
      wr_snap = n_wr;
      rv_snap = n_rv;
      rst_n = 1'b0;
      disp_req = 1'b0;
      disp_addr = 11'h7AB;
      cpu_set(0, 0, 0, 0);
      settle();
      check("t5_rst_full", wfifo_full, 0);
      check("t5_rst_we", sram_we, 0);
      check("t5_rst_addr", sram_addr, 11'h7AB);
      exp_wr.delete();
      exp_rd.delete();
      for (int i = 0; i < 3; i++) ref_mem['h300 + i] = init_val('h300 + i);
      adv();
      settle();
      adv();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         settle();
         adv();
      end
      check("t5_no_writes", n_wr, wr_snap);
      check("t5_no_rvalid", n_rv, rv_snap);
      check("t5_full_after", wfifo_full, 0);

      // Back-to-back reads
      cpu_set(1, 0, 'h010, 0);
      settle();
      check("t6_ack0", cpu_ack, 1);
      adv();
      cpu_set(1, 0, 'h011, 0);
      for (int i = 1; i < 3; i++) begin
         settle();
         check("t6_stall", cpu_ack, 0);
         adv();
      end
      settle();
      check("t6_ack1", cpu_ack, 1);
      check("t6_rvalid0", cpu_rvalid, 1);
      check("t6_rdata0", cpu_rdata, 8'hAA);
      adv();
      cpu_set(0, 0, 0, 0);
      for (int i = 4; i < 6; i++) begin
         settle();
         check("t6_gap", cpu_rvalid, 0);
         adv();
      end
      settle();
      check("t6_rvalid1", cpu_rvalid, 1);
      check("t6_rdata1", cpu_rdata, 8'h55);
      adv();
      settle();
      adv();

      check("end_wr_queue", exp_wr.size(), 0);
      check("end_rd_queue", exp_rd.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
